conv_window_ctrl: RTL and testbench

CONV_WINDOW_CTRL -- requirements
Module: conv_window_ctrl

---
 rtl/conv_window_ctrl_if.sv | 33 +++
 rtl/conv_window_ctrl.sv | 141 ++++++++++++++
 tb/tb_conv_window_ctrl.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/conv_window_ctrl_if.sv
// Bus bundle for conv_window_ctrl: start/busy/done control, feature-map read port,
// conv datapath hookup and the result handshake.
interface conv_window_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int K          = 3
);
  logic                         start;
  logic                         busy;
  logic                         done;
  logic                         act_rd_en;
  logic [15:0]                  act_rd_addr;
  logic [DATA_WIDTH-1:0]        act_rd_data;
  logic [K*K*DATA_WIDTH-1:0]    win_act;
  logic                         conv_ce;
  logic [DATA_WIDTH-1:0]        conv_op;
  logic                         out_valid;
  logic                         out_ready;
  logic [DATA_WIDTH-1:0]        out_data;
  logic [7:0]                   out_row;
  logic [7:0]                   out_col;

  modport master (
    output start, act_rd_data, conv_op, out_ready,
    input  busy, done, act_rd_en, act_rd_addr, win_act, conv_ce,
           out_valid, out_data, out_row, out_col
  );

  modport slave (
    input  start, act_rd_data, conv_op, out_ready,
    output busy, done, act_rd_en, act_rd_addr, win_act, conv_ce,
           out_valid, out_data, out_row, out_col
  );
endinterface

// File: rtl/conv_window_ctrl.sv
// Sliding-window controller: refetches a KxK window per output position, clocks the
// conv datapath for CONV_LAT cycles, then hands the result downstream.
module conv_window_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int K          = 3,
  parameter int S          = 1,
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 8,
  parameter int CONV_LAT   = 11
) (
  input logic               clk,
  input logic               global_rst,
  conv_window_ctrl_if.slave bus
);
  localparam int KK      = K * K;
  localparam int OW      = (IMG_W - K) / S + 1;
  localparam int OH      = (IMG_H - K) / S + 1;
  localparam int CNT_MAX = (KK > CONV_LAT) ? KK : CONV_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] KK_C  = CNT_W'(KK);
  localparam logic [CNT_W-1:0] LAT_C = CNT_W'(CONV_LAT);
  localparam logic [7:0]       OW_M1 = 8'(OW - 1);
  localparam logic [7:0]       OH_M1 = 8'(OH - 1);

  typedef enum logic [2:0] {IDLE, FETCH, COMPUTE, OUTPUT, DONE} state_e;

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [7:0]               row_q, row_d, col_q, col_d;
  logic [KK*DATA_WIDTH-1:0] win_q, win_d;
  logic [DATA_WIDTH-1:0]    res_q, res_d;
  logic [7:0]               orow_q, orow_d, ocol_q, ocol_d;
  int                       rd_r, rd_c;

  always_ff @(posedge clk or posedge global_rst) begin
    if (global_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      win_q   <= '0;
      res_q   <= '0;
      orow_q  <= '0;
      ocol_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      col_q   <= col_d;
      win_q   <= win_d;
      res_q   <= res_d;
      orow_q  <= orow_d;
      ocol_q  <= ocol_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    row_d           = row_q;
    col_d           = col_q;
    win_d           = win_q;
    res_d           = res_q;
    orow_d          = orow_q;
    ocol_d          = ocol_q;
    rd_r            = int'(cnt_q) / K;
    rd_c            = int'(cnt_q) % K;
    bus.busy        = 1'b0;
    bus.done        = 1'b0;
    bus.act_rd_en   = 1'b0;
    bus.act_rd_addr = '0;
    bus.conv_ce     = 1'b0;
    bus.out_valid   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = FETCH;
          cnt_d   = '0;
          row_d   = '0;
          col_d   = '0;
        end
      end
      FETCH: begin
        bus.busy = 1'b1;
        if (cnt_q < KK_C) begin
          bus.act_rd_en   = 1'b1;
          bus.act_rd_addr = 16'((int'(row_q) * S + rd_r) * IMG_W + int'(col_q) * S + rd_c);
        end
        // Read data lags its strobe by one cycle, so slot i lands while cnt == i+1.
        for (int i = 0; i < KK; i++)
          if (int'(cnt_q) == i + 1) win_d[i*DATA_WIDTH +: DATA_WIDTH] = bus.act_rd_data;
        if (cnt_q == KK_C) begin
          state_d = COMPUTE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      COMPUTE: begin
        bus.busy = 1'b1;
        if (cnt_q < LAT_C) begin
          bus.conv_ce = 1'b1;
          cnt_d       = cnt_q + 1'b1;
        end else begin
          res_d   = bus.conv_op;
          orow_d  = row_q;
          ocol_d  = col_q;
          cnt_d   = '0;
          state_d = OUTPUT;
        end
      end
      OUTPUT: begin
        bus.busy      = 1'b1;
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          if (col_q < OW_M1) begin
            col_d   = col_q + 8'd1;
            state_d = FETCH;
          end else if (row_q < OH_M1) begin
            col_d   = '0;
            row_d   = row_q + 8'd1;
            state_d = FETCH;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        bus.done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.win_act  = win_q;
  assign bus.out_data = res_q;
  assign bus.out_row  = orow_q;
  assign bus.out_col  = ocol_q;
endmodule

// File: tb/tb_conv_window_ctrl.sv
// Directed bench: 4x4/S=1 and 5x5/S=2 maps, word = address, conv = window sum.
module tb_conv_window_ctrl;
  logic clk = 1'b0;
  logic global_rst;
  int   cyc = 0;
  int   pass_cnt = 0;
  int   fail_cnt = 0;
  int   chk_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  conv_window_ctrl_if #(.DATA_WIDTH(32), .K(3)) a_if ();
  conv_window_ctrl_if #(.DATA_WIDTH(32), .K(3)) b_if ();

  conv_window_ctrl #(.IMG_W(4), .IMG_H(4)) dut_a (.clk(clk), .global_rst(global_rst), .bus(a_if));
  conv_window_ctrl #(.IMG_W(5), .IMG_H(5), .S(2)) dut_b (.clk(clk), .global_rst(global_rst), .bus(b_if));

  function automatic logic [31:0] win_sum(input logic [9*32-1:0] w);
    logic [31:0] s;
    s = '0;
    for (int i = 0; i < 9; i++) s = s + w[i*32 +: 32];
    return s;
  endfunction

  // Memory returns its own address one cycle after the strobe.
  always @(posedge clk) if (a_if.act_rd_en) a_if.act_rd_data <= 32'(a_if.act_rd_addr);
  always @(posedge clk) if (b_if.act_rd_en) b_if.act_rd_data <= 32'(b_if.act_rd_addr);
  assign a_if.conv_op = win_sum(a_if.win_act);
  assign b_if.conv_op = win_sum(b_if.win_act);

  int a_data[$], a_row[$], a_col[$], a_rdw[$], a_cew[$], a_vrise[$];
  int a_rd_tot = 0, a_rd_since = 0, a_ce_since = 0, a_done = 0;
  int b_data[$], b_row[$], b_col[$], b_first[$];
  int b_done = 0;

  initial begin
    logic a_pv, b_pe;
    a_pv = 1'b0;
    b_pe = 1'b0;
    forever begin
      @(negedge clk);
      if (global_rst) begin
        a_rd_since = 0;
        a_ce_since = 0;
        a_pv = 1'b0;
        b_pe = 1'b0;
      end else begin
        if (a_if.act_rd_en) begin a_rd_tot++; a_rd_since++; end
        if (a_if.conv_ce) a_ce_since++;
        if (a_if.done) a_done++;
        if (a_if.out_valid && !a_pv) a_vrise.push_back(cyc);
        if (a_if.out_valid && a_if.out_ready) begin
          a_data.push_back(int'(a_if.out_data));
          a_row.push_back(int'(a_if.out_row));
          a_col.push_back(int'(a_if.out_col));
          a_rdw.push_back(a_rd_since);
          a_cew.push_back(a_ce_since);
          a_rd_since = 0;
          a_ce_since = 0;
        end
        a_pv = a_if.out_valid;
        if (b_if.act_rd_en && !b_pe) b_first.push_back(int'(b_if.act_rd_addr));
        b_pe = b_if.act_rd_en;
        if (b_if.done) b_done++;
        if (b_if.out_valid && b_if.out_ready) begin
          b_data.push_back(int'(b_if.out_data));
          b_row.push_back(int'(b_if.out_row));
          b_col.push_back(int'(b_if.out_col));
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  int exp_a[4] = '{45, 54, 81, 90};
  int exp_b[4] = '{54, 72, 144, 162};
  int exp_bf[4] = '{0, 2, 10, 12};

  task automatic run_a(input string tag, output int t0, output int base);
    int d0;
    base = a_data.size();
    d0   = a_done;
    a_if.start = 1'b1;
    @(posedge clk); #1;
    a_if.start = 1'b0;
    t0 = cyc;
    chk({tag, "_busy"}, 64'(a_if.busy), 64'(1));
    for (int i = 0; i < 600 && a_done == d0; i++) begin @(posedge clk); #1; end
    chk({tag, "_done"}, 64'(a_done), 64'(d0 + 1));
    chk({tag, "_nres"}, 64'(a_data.size() - base), 64'(4));
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_data"}, 64'(a_data[base+i]), 64'(exp_a[i]));
      chk({tag, "_row"}, 64'(a_row[base+i]), 64'(i / 2));
      chk({tag, "_col"}, 64'(a_col[base+i]), 64'(i % 2));
    end
  endtask

  initial begin
    int t0, base, vb, d0, snap;
    global_rst = 1'b1;
    a_if.start = 1'b0; a_if.out_ready = 1'b1;
    b_if.start = 1'b0; b_if.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(a_if.busy), 64'(0));
    chk("rst_done", 64'(a_if.done), 64'(0));
    chk("rst_rd_en", 64'(a_if.act_rd_en), 64'(0));
    chk("rst_addr", 64'(a_if.act_rd_addr), 64'(0));
    chk("rst_ce", 64'(a_if.conv_ce), 64'(0));
    chk("rst_valid", 64'(a_if.out_valid), 64'(0));
    chk("rst_data", 64'(a_if.out_data), 64'(0));
    chk("rst_win_zero", 64'(a_if.win_act === '0), 64'(1));
    global_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Run 1: free-flowing output, timing and per-window strobe counts.
    vb = a_vrise.size();
    run_a("run1", t0, base);
    chk("run1_first_valid_lat", 64'(a_vrise[vb] - t0), 64'(22));
    for (int i = 0; i < 4; i++) begin
      chk("run1_rd_per_win", 64'(a_rdw[base+i]), 64'(9));
      chk("run1_ce_per_win", 64'(a_cew[base+i]), 64'(11));
    end
    repeat (3) @(posedge clk);
    #1;
    chk("run1_single_done", 64'(a_done), 64'(1));
    chk("run1_idle_busy", 64'(a_if.busy), 64'(0));

    // Run 2: backpressure on the first result, plus stray starts while busy.
    a_if.out_ready = 1'b0;
    base = a_data.size();
    d0 = a_done;
    a_if.start = 1'b1;
    @(posedge clk); #1;
    a_if.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    a_if.start = 1'b1;
    @(posedge clk); #1;
    a_if.start = 1'b0;
    for (int i = 0; i < 100 && !a_if.out_valid; i++) begin @(posedge clk); #1; end
    chk("run2_valid_seen", 64'(a_if.out_valid), 64'(1));
    snap = a_rd_tot;
    for (int k = 0; k < 5; k++) begin
      a_if.start = (k == 1);
      @(posedge clk); #1;
      chk("run2_hold_valid", 64'(a_if.out_valid), 64'(1));
      chk("run2_hold_data", 64'(a_if.out_data), 64'(45));
      chk("run2_hold_no_rd", 64'(a_rd_tot), 64'(snap));
    end
    a_if.start = 1'b0;
    a_if.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("run2_valid_drop", 64'(a_if.out_valid), 64'(0));
    chk("run2_advanced", 64'(a_if.act_rd_en), 64'(1));
    for (int i = 0; i < 600 && a_done == d0; i++) begin @(posedge clk); #1; end
    chk("run2_done", 64'(a_done), 64'(d0 + 1));
    chk("run2_nres", 64'(a_data.size() - base), 64'(4));
    for (int i = 0; i < 4; i++)
      chk("run2_data", 64'(a_data[base+i]), 64'(exp_a[i]));
    repeat (2) @(posedge clk);
    #1;

    // Run 3: reset while the second window is computing, then a clean rerun.
    base = a_data.size();
    d0 = a_done;
    a_if.start = 1'b1;
    @(posedge clk); #1;
    a_if.start = 1'b0;
    for (int i = 0; i < 200 && !(a_data.size() == base + 1 && a_if.conv_ce); i++) begin
      @(posedge clk); #1;
    end
    chk("run3_in_w2_compute", 64'(a_if.conv_ce && a_data.size() == base + 1), 64'(1));
    global_rst = 1'b1;
    #1;
    chk("run3_rst_busy", 64'(a_if.busy), 64'(0));
    chk("run3_rst_ce", 64'(a_if.conv_ce), 64'(0));
    chk("run3_rst_rd_en", 64'(a_if.act_rd_en), 64'(0));
    chk("run3_rst_valid", 64'(a_if.out_valid), 64'(0));
    chk("run3_rst_data", 64'(a_if.out_data), 64'(0));
    chk("run3_rst_row", 64'(a_if.out_row), 64'(0));
    chk("run3_rst_col", 64'(a_if.out_col), 64'(0));
    chk("run3_rst_win_zero", 64'(a_if.win_act === '0), 64'(1));
    repeat (3) @(posedge clk);
    #1;
    global_rst = 1'b0;
    @(posedge clk); #1;
    chk("run3_idle_after_rst", 64'(a_if.busy), 64'(0));
    chk("run3_no_done", 64'(a_done), 64'(d0));
    run_a("run3", t0, base);

    // Run 4: 5x5 map with stride 2.
    base = b_data.size();
    vb = b_first.size();
    d0 = b_done;
    b_if.start = 1'b1;
    @(posedge clk); #1;
    b_if.start = 1'b0;
    for (int i = 0; i < 600 && b_done == d0; i++) begin @(posedge clk); #1; end
    chk("s2_done", 64'(b_done), 64'(d0 + 1));
    chk("s2_nwin", 64'(b_first.size() - vb), 64'(4));
    for (int i = 0; i < 4; i++) begin
      chk("s2_first_addr", 64'(b_first[vb+i]), 64'(exp_bf[i]));
      chk("s2_data", 64'(b_data[base+i]), 64'(exp_b[i]));
      chk("s2_row", 64'(b_row[base+i]), 64'(i / 2));
      chk("s2_col", 64'(b_col[base+i]), 64'(i % 2));
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
